vec_dmem_seq: RTL and testbench

VEC_DMEM_SEQ -- requirements
Module: vec_dmem_seq

---
 rtl/vec_dmem_pkg.sv | 19 +
 rtl/dmem_word_ram.sv | 33 +++
 rtl/vec_dmem_seq.sv | 132 +++++++++++++
 tb/tb_vec_dmem_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_dmem_pkg.sv
// Shared types and defaults for the vector data-memory sequencer.
// Holds the FSM state encoding and the beat-count helper.
package vec_dmem_pkg;

  localparam int S_DEF     = 32;
  localparam int LANES_DEF = 6;
  localparam int DEPTH_DEF = 30015;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_t;

  function automatic int beat_count(input logic vector, input int lanes);
    return vector ? lanes : 1;
  endfunction

endpackage

// File: rtl/dmem_word_ram.sv
// Single-port word RAM with a registered read; latency 1 cycle, no backpressure.
// Out-of-range addresses read as zero and ignore writes.
module dmem_word_ram
  import vec_dmem_pkg::*;
#(
  parameter int S     = S_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [S-1:0]  wdata,
  output logic [S-1:0]  rdata
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [S-1:0]  mem [DEPTH] = '{default: '0};
  logic          in_range;
  logic [IW-1:0] idx;

  assign in_range = addr < AW'(DEPTH);
  assign idx      = addr[IW-1:0];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= wdata;
    end
    rdata <= in_range ? mem[idx] : '0;
  end

endmodule

// File: rtl/vec_dmem_seq.sv
// Sequences scalar/vector requests into one RAM word per cycle; latency N+1 cycles.
// Backpressure: one request in flight, response held in RESP until resp_ready.
module vec_dmem_seq
  import vec_dmem_pkg::*;
#(
  parameter int S     = S_DEF,
  parameter int LANES = LANES_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic                 req_vector,
  input  logic [AW-1:0]        req_addr,
  input  logic [S*LANES-1:0]   req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [S*LANES-1:0]   resp_rdata,
  output logic                 resp_err
);

  localparam int BW  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW1 = AW + 1;

  state_t                  state, state_nxt;
  logic                    we_q, err_q;
  logic [AW-1:0]           addr_q;
  logic [BW-1:0]           beat, last_beat;
  logic [LANES-1:0][S-1:0] wdata_q, rbuf;
  logic                    accept, range_err, last;
  logic [AW:0]             end_addr;

  logic                    ram_we;
  logic [AW-1:0]           ram_addr;
  logic [S-1:0]            ram_wdata, ram_rdata;

  // One extra address bit so a base near the top of the AW range cannot wrap into range.
  assign end_addr  = {1'b0, req_addr} + AW1'(beat_count(req_vector, LANES)) - AW1'(1);
  assign range_err = end_addr >= AW1'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign last      = beat == last_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = range_err ? RESP : XFER;
        end
      end
      XFER: begin
        if (last) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reads look one word ahead (the RAM read is registered), so beat k's word
  // is on ram_rdata during beat k's cycle; IDLE prefetches the request base.
  always_comb begin
    ram_addr  = req_addr;
    ram_we    = 1'b0;
    ram_wdata = wdata_q[beat];
    if (state == XFER) begin
      ram_addr = addr_q + AW'(beat) + AW'(!we_q);
      ram_we   = we_q && !rst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      beat      <= '0;
      last_beat <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
    end else if (accept) begin
      we_q      <= req_we;
      err_q     <= range_err;
      addr_q    <= req_addr;
      beat      <= '0;
      last_beat <= BW'(beat_count(req_vector, LANES) - 1);
      wdata_q   <= req_wdata;
      rbuf      <= '0;
    end else if (state == XFER) begin
      if (!we_q) begin
        rbuf[beat] <= ram_rdata;
      end
      beat <= last ? '0 : beat + 1'b1;
    end
  end

  assign resp_rdata = rbuf;
  assign resp_err   = err_q;

  dmem_word_ram #(
    .S     (S),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_vec_dmem_seq.sv
// Table-driven bench for vec_dmem_seq with a response scoreboard queue.
module tb_vec_dmem_seq;

  localparam int S     = 32;
  localparam int LANES = 6;
  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int V     = S * LANES;
  localparam int NT    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_vector;
  logic [AW-1:0] req_addr;
  logic [V-1:0]  req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [V-1:0]  resp_rdata;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          we;
    logic          vec;
    logic [AW-1:0] addr;
    logic [V-1:0]  wdata;
    logic [V-1:0]  rdata;
    logic          err;
    int            lat;
  } vec_t;

  typedef struct {
    logic [V-1:0] rdata;
    logic         err;
    int           lat;
  } exp_t;

  vec_t tbl [NT];
  exp_t sbq [$];

  always #5 clk = ~clk;

  vec_dmem_seq #(
    .S     (S),
    .LANES (LANES),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_vector (req_vector),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  function automatic logic [V-1:0] mk(input logic [31:0] b, input logic [31:0] s);
    logic [V-1:0] r;
    for (int k = 0; k < LANES; k++) begin
      r[k*S +: S] = b + s * k;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [V-1:0] r, input logic e, input int l);
    exp_t x;
    x.rdata = r;
    x.err   = e;
    x.lat   = l;
    sbq.push_back(x);
  endtask

  // Waits for resp_valid after an acceptance edge, then compares against the scoreboard head.
  task automatic wait_and_compare(input string nm);
    exp_t x;
    int   n;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_valid"}, V'(resp_valid), V'(1));
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, V'(0), V'(1));
    end else begin
      x = sbq.pop_front();
      chk({nm, "_latency"}, V'(n + 1), V'(x.lat));
      chk({nm, "_rdata"}, resp_rdata, x.rdata);
      chk({nm, "_err"}, V'(resp_err), V'(x.err));
    end
  endtask

  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic run_req(input string nm, input vec_t t);
    int n;
    push_exp(t.rdata, t.err, t.lat);
    req_we     = t.we;
    req_vector = t.vec;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_and_compare(nm);
    handshake();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;

    tbl[0]  = '{1'b1, 1'b0, 32'd5,          V'(32'hDEADBEEF), '0,                  1'b0, 2};
    tbl[1]  = '{1'b0, 1'b0, 32'd5,          '0,               V'(32'hDEADBEEF),    1'b0, 2};
    tbl[2]  = '{1'b1, 1'b1, 32'd10,         mk(32'h11, 32'h11), '0,                1'b0, 7};
    tbl[3]  = '{1'b0, 1'b1, 32'd10,         '0,               mk(32'h11, 32'h11),  1'b0, 7};
    tbl[4]  = '{1'b0, 1'b0, 32'd13,         '0,               V'(32'h44),          1'b0, 2};
    tbl[5]  = '{1'b1, 1'b1, 32'd58,         mk(32'h3A0, 32'h1), '0,                1'b0, 7};
    tbl[6]  = '{1'b0, 1'b1, 32'd58,         '0,               mk(32'h3A0, 32'h1),  1'b0, 7};
    tbl[7]  = '{1'b1, 1'b1, 32'd59,         mk(32'hFFFF0000, 32'h1), '0,           1'b1, 1};
    tbl[8]  = '{1'b0, 1'b1, 32'd58,         '0,               mk(32'h3A0, 32'h1),  1'b0, 7};
    tbl[9]  = '{1'b0, 1'b0, 32'd64,         '0,               '0,                  1'b1, 1};
    tbl[10] = '{1'b0, 1'b0, 32'd63,         '0,               V'(32'h3A5),         1'b0, 2};
    tbl[11] = '{1'b1, 1'b1, 32'd12,         mk(32'hB0, 32'h1), '0,                 1'b0, 7};
    tbl[12] = '{1'b0, 1'b1, 32'd10,         '0,
                {32'hB3, 32'hB2, 32'hB1, 32'hB0, 32'h22, 32'h11},                  1'b0, 7};
    tbl[13] = '{1'b0, 1'b0, 32'hFFFF_FFFF,  '0,               '0,                  1'b1, 1};
    tbl[14] = '{1'b1, 1'b1, 32'hFFFF_FFFE,  mk(32'hC0, 32'h1), '0,                 1'b1, 1};
    tbl[15] = '{1'b0, 1'b0, 32'd0,          '0,               '0,                  1'b0, 2};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_vector = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_req_ready", V'(req_ready), V'(1));
    chk("reset_resp_valid", V'(resp_valid), V'(0));
    chk("reset_resp_err", V'(resp_err), V'(0));
    chk("reset_resp_rdata", resp_rdata, '0);

    for (int i = 0; i < NT; i++) begin
      run_req($sformatf("t%0d", i), tbl[i]);
    end

    // Backpressure: response held for 5 cycles while a second request waits.
    chk("bp_ready_pre", V'(req_ready), V'(1));
    push_exp(V'(32'hDEADBEEF), 1'b0, 2);
    req_we     = 1'b0;
    req_vector = 1'b0;
    req_addr   = 32'd5;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    push_exp(V'(32'h3A5), 1'b0, 2);
    req_addr = 32'd63;
    wait_and_compare("bp_first");
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d_valid", c), V'(resp_valid), V'(1));
      chk($sformatf("bp_hold%0d_rdata", c), resp_rdata, V'(32'hDEADBEEF));
      chk($sformatf("bp_hold%0d_err", c), V'(resp_err), V'(0));
      chk($sformatf("bp_hold%0d_req_ready", c), V'(req_ready), V'(0));
      @(posedge clk);
      #1;
    end
    handshake();
    chk("bp_after_hs_req_ready", V'(req_ready), V'(1));
    chk("bp_after_hs_resp_valid", V'(resp_valid), V'(0));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("bp_second_accepted", V'(req_ready), V'(0));
    wait_and_compare("bp_second");
    handshake();

    // Reset after beat 2 of a vector write: only lanes 0..2 may land.
    req_we     = 1'b1;
    req_vector = 1'b1;
    req_addr   = 32'd20;
    req_wdata  = mk(32'hA1, 32'h1);
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_resp_valid", V'(resp_valid), V'(0));
    chk("rst_mid_req_ready", V'(req_ready), V'(1));
    chk("rst_mid_resp_err", V'(resp_err), V'(0));
    chk("rst_mid_resp_rdata", resp_rdata, '0);
    t = '{1'b0, 1'b1, 32'd20, '0, {96'h0, 32'hA3, 32'hA2, 32'hA1}, 1'b0, 7};
    run_req("rst_mid_reread", t);

    chk("sb_drained", V'(sbq.size()), V'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
